// File: rtl/alu_pkg.sv
// Shared constants for the registered 4-bit ALU: default width and 3-bit opcodes.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_ADD = 3'b000;
    localparam alu_op_t OP_SUB = 3'b001;
    localparam alu_op_t OP_AND = 3'b010;
    localparam alu_op_t OP_OR  = 3'b011;
    localparam alu_op_t OP_XOR = 3'b100;
    localparam alu_op_t OP_NOT = 3'b101;
    localparam alu_op_t OP_SHL = 3'b110;
    localparam alu_op_t OP_SHR = 3'b111;

endpackage

// File: rtl/alu_4bit_datapath.sv
// Combinational ALU core: {carry, result} = f(a, b, alu_sel), no state.
module alu_4bit_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          alu_sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit is the carry-out for ADD and the borrow (a < b) for SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        // NOTE: defaults first so every path through the case drives both outputs; no latch.
        result = '0;
        carry  = 1'b0;
        case (alu_sel)
            OP_ADD: {carry, result} = sum;
            OP_SUB: {carry, result} = diff;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: combinational datapath followed by one output register stage.
module alu_4bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_Sel,
    output logic [WIDTH-1:0] Result,
    output logic             Carry
);

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             carry_d;
    logic             carry_q;

    alu_4bit_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .a      (A),
        .b      (B),
        .alu_sel(ALU_Sel),
        .result (result_d),
        .carry  (carry_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates for flops; reset is synchronous, so it lives only in the clocked branch.
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign Result = result_q;
    assign Carry  = carry_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed steps plus a random sweep, scoreboard-checked.
module tb_alu_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] ALU_Sel;
    logic [3:0] Result;
    logic       Carry;

    typedef struct {
        logic [3:0] result;
        logic       carry;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    alu_4bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .ALU_Sel(ALU_Sel),
        .Result (Result),
        .Carry  (Carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Independent reference written with integer arithmetic.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        exp_t e;
        int   ai = int'(a);
        int   bi = int'(b);
        int   t;
        e.carry = 1'b0;
        e.tag   = "rand";
        case (sel)
            3'd0: begin t = ai + bi; e.result = 4'(t % 16); e.carry = (t > 15); end
            3'd1: begin t = (ai - bi + 16) % 16; e.result = 4'(t); e.carry = (ai < bi); end
            3'd2: e.result = a & b;
            3'd3: e.result = a | b;
            3'd4: e.result = a ^ b;
            3'd5: e.result = 4'(15 - ai);
            3'd6: begin e.result = 4'((ai * 2) % 16); e.carry = (ai >= 8); end
            default: begin e.result = 4'(ai / 2); e.carry = (ai % 2 == 1); end
        endcase
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: output seen at %0t but nothing expected", $time);
        end else begin
            e = sb.pop_front();
            assert ({Carry, Result} === {e.carry, e.result})
            else begin
                n_fail++;
                $error("FAIL %s: got Result=%b Carry=%b, expected Result=%b Carry=%b",
                       e.tag, Result, Carry, e.result, e.carry);
            end
        end
    endtask

    // Drive at the falling edge, queue the expectation, check #1 after the next rising edge.
    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] sel, input logic [3:0] er, input logic ec,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst_n   = rst;
        A       = a;
        B       = b;
        ALU_Sel = sel;
        e.result = er;
        e.carry  = ec;
        e.tag    = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        exp_t e;
        rst_n   = 1'b0;
        A       = 4'b1010;
        B       = 4'b0101;
        ALU_Sel = 3'b000;

        step(1'b0, 4'b1010, 4'b0101, 3'b000, 4'b0000, 1'b0, "reset_1");
        step(1'b0, 4'b1010, 4'b0101, 3'b000, 4'b0000, 1'b0, "reset_2");

        step(1'b1, 4'b1010, 4'b0101, 3'b000, 4'b1111, 1'b0, "add_1010_0101");
        step(1'b1, 4'b1010, 4'b0101, 3'b001, 4'b0101, 1'b0, "sub_1010_0101");
        step(1'b1, 4'b1010, 4'b0101, 3'b010, 4'b0000, 1'b0, "and_1010_0101");
        step(1'b1, 4'b1010, 4'b0101, 3'b011, 4'b1111, 1'b0, "or_1010_0101");
        step(1'b1, 4'b1010, 4'b0101, 3'b100, 4'b1111, 1'b0, "xor_1010_0101");

        step(1'b1, 4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, "add_wrap");
        step(1'b1, 4'b0011, 4'b0101, 3'b001, 4'b1110, 1'b1, "sub_borrow");
        step(1'b1, 4'b0101, 4'b0101, 3'b001, 4'b0000, 1'b0, "sub_equal");
        step(1'b1, 4'b0000, 4'b0001, 3'b001, 4'b1111, 1'b1, "sub_wrap");

        step(1'b1, 4'b1001, 4'b1111, 3'b101, 4'b0110, 1'b0, "not_1001");
        step(1'b1, 4'b1001, 4'b0000, 3'b110, 4'b0010, 1'b1, "shl_1001");
        step(1'b1, 4'b1001, 4'b0000, 3'b111, 4'b0100, 1'b1, "shr_1001");

        // Hold: inputs change mid-cycle, outputs must keep the last registered value.
        step(1'b1, 4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, "add_before_hold");
        #2;
        A       = 4'b0101;
        B       = 4'b0011;
        ALU_Sel = 3'b000;
        #1;
        n_assert++;
        assert ({Carry, Result} === {1'b1, 4'b0000})
        else begin
            n_fail++;
            $error("FAIL hold_mid_cycle: got Result=%b Carry=%b, expected Result=0000 Carry=1",
                   Result, Carry);
        end
        e.result = 4'b1000;
        e.carry  = 1'b0;
        e.tag    = "add_after_hold";
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();

        // Reset in the middle of traffic wins over the opcode, then computation resumes.
        step(1'b0, 4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b0, "reset_mid_add");
        step(1'b1, 4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, "resume_add_wrap");
        step(1'b1, 4'b0110, 4'b0011, 3'b001, 4'b0011, 1'b0, "resume_sub");

        for (int i = 0; i < 32; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [2:0] rs;
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rs = 3'($urandom_range(7));
            e  = model(ra, rb, rs);
            step(1'b1, ra, rb, rs, e.result, e.carry, $sformatf("rand_%0d_op%0d", i, rs));
        end

        n_assert++;
        assert (sb.size() == 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
